mem_loader: RTL and testbench

- Byte-stream program/data memory loader, the write-side counterpart of the post-halt memory dump path.
- Sits between a byte source (UART RX or bench driver) and the data-memory write port of MicroArquitectura.
- Holds the CPU in reset while it fills memory with little-endian 32-bit words, then releases the CPU.

---
 rtl/mem_loader_pkg.sv | 22 ++
 rtl/mem_loader_if.sv | 25 ++
 rtl/mem_loader_packer.sv | 44 ++++
 rtl/mem_loader.sv | 165 ++++++++++++++++
 tb/tb_mem_loader.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_loader_pkg.sv
// Shared constants and state encoding for the byte-stream memory loader.
package mem_loader_pkg;

  localparam int unsigned LANE_W      = 8;
  localparam int unsigned BYTES_PER_W = 4;
  localparam int unsigned WORD_W      = LANE_W * BYTES_PER_W;
  localparam int unsigned LANE_IDX_W  = $clog2(BYTES_PER_W);
  localparam int unsigned CNT_W       = 16;

  typedef logic [LANE_W-1:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    FIN,
    ERR
  } state_t;

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream input and memory write port of the loader.
// master: byte source / memory side, slave: the loader itself.
interface mem_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  import mem_loader_pkg::*;

  byte_t               rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [WORD_W-1:0]   mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_loader_packer.sv
// Byte-to-word packer: little-endian lane fill, word_ready strobes the
// cycle after the fourth byte of a word is accepted.
module mem_loader_packer
  import mem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  byte_en,
  input  byte_t                 byte_in,
  output logic [LANE_IDX_W-1:0] lane,
  output logic [WORD_W-1:0]     word,
  output logic                  word_ready
);

  localparam int unsigned STAGE_W = WORD_W - LANE_W;

  logic [STAGE_W-1:0] stage;

  // Shift lanes in from the top so the first byte ends up in bits 7:0.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane       <= '0;
      stage      <= '0;
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (clr) begin
        lane <= '0;
      end else if (byte_en) begin
        if (lane == LANE_IDX_W'(BYTES_PER_W - 1)) begin
          word       <= {byte_in, stage};
          word_ready <= 1'b1;
          lane       <= '0;
        end else begin
          stage <= {byte_in, stage[STAGE_W-1:LANE_W]};
          lane  <= lane + LANE_IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Byte-stream memory loader: holds the CPU in reset, receives a 16-bit word
// count followed by little-endian words, writes them to data memory and
// then releases the CPU. Optional trailing XOR checksum byte enabled by
// defining MEM_LOADER_CHECKSUM_EN.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  mem_loader_if.slave bus,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t                state;
  logic [CNT_W-1:0]      len;
  logic [CNT_W-1:0]      idx;
  logic                  rx_ready_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [LANE_IDX_W-1:0] lane;
  logic [WORD_W-1:0]     word;
  logic                  word_ready;

  logic                  take_c;
  logic                  pack_c;
  logic                  clr_c;
  logic                  last_byte_c;
  logic                  last_word_c;
  logic [CNT_W-1:0]      len_c;

  assign take_c      = bus.rx_valid & rx_ready_q;
  assign pack_c      = take_c && (state == DATA);
  assign clr_c       = start && ((state == IDLE) || (state == ERR));
  assign last_byte_c = pack_c && (lane == LANE_IDX_W'(BYTES_PER_W - 1));
  assign last_word_c = (idx == len - CNT_W'(1));
  assign len_c       = {bus.rx_data, len[LANE_W-1:0]};

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = word_ready;
  assign bus.mem_wdata = word;

  mem_loader_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr_c),
    .byte_en    (pack_c),
    .byte_in    (bus.rx_data),
    .lane       (lane),
    .word       (word),
    .word_ready (word_ready)
  );

`ifdef MEM_LOADER_CHECKSUM_EN
  byte_t chk;

  // Running XOR of every accepted length and data byte of the session.
  always_ff @(posedge clk) begin
    if (rst || clr_c) begin
      chk <= '0;
    end else if (take_c) begin
      chk <= chk ^ bus.rx_data;
    end
  end
`endif

  // Session FSM; outputs updated on the transitions that change them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      idx        <= '0;
      rx_ready_q <= 1'b0;
      mem_addr_q <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, ERR: begin
          if (start) begin
            state      <= LEN_LO;
            idx        <= '0;
            err        <= 1'b0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b1;
            rx_ready_q <= 1'b1;
          end
        end
        LEN_LO: begin
          if (take_c) begin
            len[LANE_W-1:0] <= bus.rx_data;
            state           <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (take_c) begin
            len <= len_c;
            if (len_c == '0) begin
              state      <= FIN;
              rx_ready_q <= 1'b0;
              done       <= 1'b1;
              cpu_rst    <= 1'b0;
            end else if (len_c > CNT_W'(DEPTH)) begin
              state      <= ERR;
              rx_ready_q <= 1'b0;
              err        <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (last_byte_c) begin
            mem_addr_q <= ADDR_W'({idx, 2'b00});
            idx        <= idx + CNT_W'(1);
            if (last_word_c) begin
`ifdef MEM_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state      <= FIN;
              rx_ready_q <= 1'b0;
              done       <= 1'b1;
              cpu_rst    <= 1'b0;
`endif
            end
          end
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (take_c) begin
            rx_ready_q <= 1'b0;
            if (bus.rx_data == chk) begin
              state   <= FIN;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          rx_ready_q <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: stimulus pushes expected memory writes into
// a queue, a negedge monitor pops and compares each mem_we pulse.
module tb_mem_loader;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_rst, busy, done, err;

  mem_loader_if #(.ADDR_W(32)) bus ();

  mem_loader #(.DEPTH(256), .ADDR_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] img [0:255];
  logic [7:0]  txor;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every write must match the oldest expected entry.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_t e;
      checks = checks + 1;
      wr_cnt = wr_cnt + 1;
      last_addr = bus.mem_addr;
      if (bus.mem_addr < 32'd1024) img[bus.mem_addr[9:2]] = bus.mem_wdata;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_write actual addr=0x%08h data=0x%08h required none",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
          errors = errors + 1;
          $display("FAIL write actual addr=0x%08h data=0x%08h required addr=0x%08h data=0x%08h",
                   bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
      end
    end
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    txor  = 8'h00;
  endtask

  // Present one byte after 'gap' idle cycles and wait (bounded) until taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap != 0) begin
      bus.rx_valid = 1'b0;
      tick(gap);
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    txor = txor ^ b;
    t = 0;
    @(negedge clk);
    while (bus.rx_ready !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.rx_valid = 1'b0;
  endtask

  task automatic finish_payload;
`ifdef MEM_LOADER_CHECKSUM_EN
    send_byte(txor, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int   c0, w0, d0, bad;
    wr_t  e;
    logic [31:0] w;

    rst = 1'b1; start = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    txor = 8'h00;
    tick(3);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_mem_we",   32'(bus.mem_we),   32'd0);
    check("rst_mem_addr", bus.mem_addr,      32'd0);
    check("rst_wdata",    bus.mem_wdata,     32'd0);
    check("rst_cpu_rst",  32'(cpu_rst),      32'd1);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_done",     32'(done),         32'd0);
    check("rst_err",      32'(err),          32'd0);
    rst = 1'b0;
    tick(1);

    // Two words at full rate.
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_cpu_rst_held", 32'(cpu_rst), 32'd1);
    e.addr = 32'd0; e.data = 32'h12345678; exp_q.push_back(e);
    e.addr = 32'd4; e.data = 32'hDEADBEEF; exp_q.push_back(e);
    c0 = cyc;
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
    check("t1_no_stall_cycles", 32'(cyc - c0), 32'd10);
    finish_payload();
    idle();
    tick(3);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_cpu_rst_released", 32'(cpu_rst), 32'd0);
    check("t1_busy_idle", 32'(busy), 32'd0);
    check("t1_queue_drained", 32'(exp_q.size()), 32'd0);
    check("t1_addr_hold", bus.mem_addr, 32'd4);
    check("t1_wdata_hold", bus.mem_wdata, 32'hDEADBEEF);

    // Zero-length load.
    w0 = wr_cnt;
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    idle();
    check("t2_done_after_len_hi", 32'(done), 32'd1);
    tick(1);
    check("t2_done_one_cycle", 32'(done), 32'd0);
    check("t2_cpu_rst", 32'(cpu_rst), 32'd0);
    check("t2_no_writes", 32'(wr_cnt - w0), 32'd0);
    check("t2_done_cnt", 32'(done_cnt), 32'd2);

    // Length 257 exceeds DEPTH.
    pulse_start();
    check("t3_cpu_rst_reasserted", 32'(cpu_rst), 32'd1);
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    idle();
    check("t3_err", 32'(err), 32'd1);
    check("t3_rx_ready", 32'(bus.rx_ready), 32'd0);
    tick(3);
    check("t3_err_sticky", 32'(err), 32'd1);
    check("t3_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_no_writes", 32'(wr_cnt - w0), 32'd0);
    pulse_start();
    check("t3_err_cleared", 32'(err), 32'd0);
    check("t3_rx_ready_again", 32'(bus.rx_ready), 32'd1);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    idle();
    tick(2);
    check("t3_done_cnt", 32'(done_cnt), 32'd3);

    // Full-depth load with random valid gaps.
    w0 = wr_cnt;
    d0 = done_cnt;
    pulse_start();
    send_byte(8'h00, $urandom_range(0, 2));
    send_byte(8'h01, $urandom_range(0, 2));
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(4*i + j);
      e.addr = 32'(4*i); e.data = w; exp_q.push_back(e);
      for (int j = 0; j < 4; j++) send_byte(8'(4*i + j), $urandom_range(0, 2));
    end
    finish_payload();
    idle();
    tick(3);
    check("t4_write_count", 32'(wr_cnt - w0), 32'd256);
    check("t4_last_addr", last_addr, 32'd1020);
    check("t4_done", 32'(done_cnt - d0), 32'd1);
    check("t4_queue_drained", 32'(exp_q.size()), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(4*i + j);
      if (img[i] !== w) bad++;
    end
    check("t4_dump_mismatches", 32'(bad), 32'd0);

    // Reset in the middle of a 3-word load.
    w0 = wr_cnt;
    d0 = done_cnt;
    pulse_start();
    e.addr = 32'd0; e.data = 32'h04030201; exp_q.push_back(e);
    send_byte(8'h03, 0); send_byte(8'h00, 0);
    for (int j = 1; j <= 6; j++) send_byte(8'(j), 0);
    idle();
    rst = 1'b1;
    tick(1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t5_rx_ready", 32'(bus.rx_ready), 32'd0);
    rst = 1'b0;
    tick(3);
    check("t5_one_write", 32'(wr_cnt - w0), 32'd1);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_queue_drained", 32'(exp_q.size()), 32'd0);

    // Fresh one-word load after the aborted session starts from lane 0.
    pulse_start();
    e.addr = 32'd0; e.data = 32'hDDCCBBAA; exp_q.push_back(e);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    finish_payload();
    idle();
    tick(3);
    check("t6_done", 32'(done_cnt - d0), 32'd1);
    check("t6_queue_drained", 32'(exp_q.size()), 32'd0);

`ifdef MEM_LOADER_CHECKSUM_EN
    // Checksum: 01^00^11^22^33^44 = 45.
    d0 = done_cnt;
    pulse_start();
    e.addr = 32'd0; e.data = 32'h44332211; exp_q.push_back(e);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h45, 0);
    idle();
    tick(3);
    check("c1_done", 32'(done_cnt - d0), 32'd1);
    check("c1_err", 32'(err), 32'd0);
    check("c1_cpu_rst", 32'(cpu_rst), 32'd0);
    pulse_start();
    e.addr = 32'd0; e.data = 32'h44332211; exp_q.push_back(e);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h00, 0);
    idle();
    tick(3);
    check("c2_err", 32'(err), 32'd1);
    check("c2_cpu_rst", 32'(cpu_rst), 32'd1);
    check("c2_no_done", 32'(done_cnt - d0), 32'd1);
    check("c2_queue_drained", 32'(exp_q.size()), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
